// File: rtl/mux41_arbiter_pkg.sv
// Shared types for the round-robin mux arbiter.
// Arbiter states and requester count.
package mux41_arbiter_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int NREQ = 4;
endpackage

// File: rtl/mux41.sv
// Plain 4:1 datapath multiplexer.
// Select is expected to come from a register.
module mux41 #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Y
);
  always_comb begin
    unique case (S)
      2'd0: Y = D0;
      2'd1: Y = D1;
      2'd2: Y = D2;
      2'd3: Y = D3;
    endcase
  end
endmodule

// File: rtl/mux41_arbiter.sv
// Round-robin sequencer sharing one mux41
// among four requesters with a valid/ready output.
module mux41_arbiter
  import mux41_arbiter_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       REQ,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  output logic [3:0]       ACK,
  output logic [3:0]       GNT,
  output logic [1:0]       S,
  output logic [WIDTH-1:0] Y,
  output logic             Y_VALID,
  input  logic             Y_READY,
  output logic [CNTW-1:0]  CNT
);
  state_t          state;
  state_t          nextState;
  logic [1:0]      sel;
  logic [1:0]      ptr;
  logic [1:0]      winner;
  logic [CNTW-1:0] cnt;
  logic            accept;
  logic            leave;

  // First set request after the last grant, wrapping.
  function automatic logic [1:0] rrPick(
    input logic [3:0] req,
    input logic [1:0] last
  );
    logic [1:0] idx;
    logic       found;
    rrPick = last;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        rrPick = idx;
        found  = 1'b1;
      end
    end
  endfunction

  assign winner = rrPick(REQ, ptr);
  assign accept = (state == XFER) && Y_READY;
  assign leave  = (state == XFER) &&
                  (Y_READY || !REQ[sel]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (|REQ) nextState = XFER;
      XFER: if (leave) nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= 2'b00;
      ptr <= 2'b11;
      cnt <= '0;
    end else begin
      if ((state == IDLE) && (|REQ)) begin
        sel <= winner;
      end
      // Abort also advances ptr so a withdrawn requester loses its turn.
      if (leave) begin
        ptr <= sel;
      end
      if (accept) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    Y_VALID = 1'b0;
    GNT     = 4'b0000;
    ACK     = 4'b0000;
    if (state == XFER) begin
      Y_VALID = 1'b1;
      GNT     = 4'b0001 << sel;
      if (Y_READY) ACK = 4'b0001 << sel;
    end
  end

  assign S   = sel;
  assign CNT = cnt;

  mux41 #(
    .WIDTH(WIDTH)
  ) uMux (
    .D0(D0),
    .D1(D1),
    .D2(D2),
    .D3(D3),
    .S (sel),
    .Y (Y)
  );
endmodule

// File: tb/tb_mux41_arbiter.sv
// Directed bench for mux41_arbiter.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_mux41_arbiter;
  logic       clk;
  logic       rst_n;
  logic [3:0] REQ;
  logic [4:0] D0, D1, D2, D3;
  logic       Y_READY;
  logic [3:0] ACK, GNT;
  logic [1:0] S;
  logic [4:0] Y;
  logic       Y_VALID;
  logic [7:0] CNT;
  logic [3:0] sAck, sGnt;
  logic [1:0] sS;
  logic [4:0] sY;
  logic       sValid;
  logic [2:0] sCnt;

  int passed = 0;
  int total  = 0;

  mux41_arbiter #(.WIDTH(5), .CNTW(8)) uDut (
    .clk(clk), .rst_n(rst_n), .REQ(REQ),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .ACK(ACK), .GNT(GNT), .S(S), .Y(Y),
    .Y_VALID(Y_VALID), .Y_READY(Y_READY),
    .CNT(CNT)
  );

  mux41_arbiter #(.WIDTH(5), .CNTW(3)) uSmall (
    .clk(clk), .rst_n(rst_n), .REQ(REQ),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .ACK(sAck), .GNT(sGnt), .S(sS), .Y(sY),
    .Y_VALID(sValid), .Y_READY(Y_READY),
    .CNT(sCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic doReset();
    rst_n   = 1'b0;
    REQ     = 4'b0000;
    Y_READY = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    total++;
    if (Y_VALID !== 1'b0) $display("FAIL rst_valid: got %b want 0", Y_VALID);
    else passed++;
    total++;
    if (GNT !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", GNT);
    else passed++;
    total++;
    if (ACK !== 4'b0000) $display("FAIL rst_ack: got %b want 0000", ACK);
    else passed++;
    total++;
    if (S !== 2'b00) $display("FAIL rst_s: got %0d want 0", S);
    else passed++;
    total++;
    if (CNT !== 8'd0) $display("FAIL rst_cnt: got %0d want 0", CNT);
    else passed++;
  endtask

  task automatic test_single();
    doReset();
    D0 = 5'b10101;
    REQ = 4'b0001;
    Y_READY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (Y_VALID !== 1'b1 || S !== 2'd0 || Y !== 5'b10101)
      $display("FAIL single_xfer: got v=%b s=%0d y=%b want v=1 s=0 y=10101",
               Y_VALID, S, Y);
    else passed++;
    total++;
    if (ACK !== 4'b0001) $display("FAIL single_ack: got %b want 0001", ACK);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    REQ = 4'b0000;
    total++;
    if (Y_VALID !== 1'b0 || CNT !== 8'd1 || ACK !== 4'b0000)
      $display("FAIL single_after: got v=%b cnt=%0d ack=%b want v=0 cnt=1 ack=0000",
               Y_VALID, CNT, ACK);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0] expS [5];
    logic [4:0] expY [5];
    expS = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    expY = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1};
    doReset();
    D0 = 5'd1; D1 = 5'd2; D2 = 5'd3; D3 = 5'd4;
    REQ = 4'b1111;
    Y_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (Y_VALID !== 1'b1 || S !== expS[i] || Y !== expY[i] ||
          ACK !== (4'b0001 << expS[i]))
        $display("FAIL rr_grant%0d: got v=%b s=%0d y=%b ack=%b want v=1 s=%0d y=%b",
                 i, Y_VALID, S, Y, ACK, expS[i], expY[i]);
      else passed++;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (Y_VALID !== 1'b0) $display("FAIL rr_gap%0d: got v=%b want 0", i, Y_VALID);
      else passed++;
    end
    REQ = 4'b0000;
    total++;
    if (CNT !== 8'd5) $display("FAIL rr_cnt: got %0d want 5", CNT);
    else passed++;
  endtask

  task automatic test_hold();
    logic [7:0] c0;
    c0 = CNT;
    D2 = 5'b11100;
    REQ = 4'b0100;
    Y_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (Y_VALID !== 1'b1 || S !== 2'd2 || Y !== 5'b11100 || ACK !== 4'b0000)
        $display("FAIL hold%0d: got v=%b s=%0d y=%b ack=%b want v=1 s=2 y=11100 ack=0000",
                 i, Y_VALID, S, Y, ACK);
      else passed++;
    end
    Y_READY = 1'b1;
    #1;
    total++;
    if (ACK !== 4'b0100) $display("FAIL hold_ack: got %b want 0100", ACK);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    REQ = 4'b0000;
    total++;
    if (CNT !== c0 + 8'd1 || Y_VALID !== 1'b0)
      $display("FAIL hold_done: got cnt=%0d v=%b want cnt=%0d v=0",
               CNT, Y_VALID, c0 + 8'd1);
    else passed++;
  endtask

  task automatic test_abort();
    doReset();
    D0 = 5'd7; D1 = 5'd9;
    REQ = 4'b0010;
    Y_READY = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (GNT !== 4'b0010 || S !== 2'd1)
      $display("FAIL abort_grant: got gnt=%b s=%0d want gnt=0010 s=1", GNT, S);
    else passed++;
    REQ = 4'b0000;
    #1;
    total++;
    if (ACK !== 4'b0000) $display("FAIL abort_ack: got %b want 0000", ACK);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (Y_VALID !== 1'b0 || CNT !== 8'd0)
      $display("FAIL abort_after: got v=%b cnt=%0d want v=0 cnt=0", Y_VALID, CNT);
    else passed++;
    REQ = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (S !== 2'd0 || GNT !== 4'b0001 || Y !== 5'd7)
      $display("FAIL abort_next: got s=%0d gnt=%b y=%0d want s=0 gnt=0001 y=7",
               S, GNT, Y);
    else passed++;
    Y_READY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    REQ = 4'b0000;
  endtask

  task automatic test_async_reset();
    doReset();
    D0 = 5'd5; D3 = 5'd30;
    REQ = 4'b0001;
    Y_READY = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    Y_READY = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (Y_VALID !== 1'b1 || CNT !== 8'd1)
      $display("FAIL ar_pre: got v=%b cnt=%0d want v=1 cnt=1", Y_VALID, CNT);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (Y_VALID !== 1'b0 || GNT !== 4'b0000 || CNT !== 8'd0 || ACK !== 4'b0000)
      $display("FAIL ar_drop: got v=%b gnt=%b cnt=%0d ack=%b want all 0",
               Y_VALID, GNT, CNT, ACK);
    else passed++;
    REQ = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (S !== 2'd3 || GNT !== 4'b1000 || Y !== 5'd30)
      $display("FAIL ar_regrant: got s=%0d gnt=%b y=%0d want s=3 gnt=1000 y=30",
               S, GNT, Y);
    else passed++;
    Y_READY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    REQ = 4'b0000;
  endtask

  task automatic test_wrap();
    logic [2:0] want;
    doReset();
    REQ = 4'b0001;
    Y_READY = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      want = 3'((i + 1) % 8);
      total++;
      if (sCnt !== want) $display("FAIL wrap%0d: got %0d want %0d", i, sCnt, want);
      else passed++;
    end
    REQ = 4'b0000;
    total++;
    if (CNT !== 8'd9) $display("FAIL wrap_wide: got %0d want 9", CNT);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    REQ = 4'b0000;
    Y_READY = 1'b0;
    D0 = '0; D1 = '0; D2 = '0; D3 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_abort();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
